load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the 32-bit ALU.
- Takes the ALU result as the effective address and the rt register value as store data.
- Runs one byte, halfword or word access against data memory using a req/ack handshake, then returns the sign- or zero-extended load data to the writeback path.
- Holds busy high for the whole access so the control unit can stall the PC.

Parameters:
TIMEOUT, 16, max cycles mem_req waits for mem_ack before fault; 0 disables timeout
CNT_W, 8, width of timeout counter; must satisfy 2**CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request pulse from control; sampled only in IDLE
we  input  1  1 = store, 0 = load
size  input  2  00 byte, 01 half, 10 word, 11 illegal
uns  input  1  loads only: 1 = zero-extend, 0 = sign-extend
addr  input  32  effective address (ALU output y)
wdata  input  32  store data (rt), right-justified
busy  output  1  high from the cycle after accepted start through the DONE cycle
done  output  1  one-cycle pulse: access finished
fault  output  1  valid with done: misaligned, illegal size, or timeout
rdata  output  32  extended load data, valid with done; held until next done
mem_req  output  1  memory request, registered
mem_we  output  1  memory write enable
mem_addr  output  32  word address, {addr[31:2],2'b00}
mem_be  output  4  byte enables, little-endian lane order
mem_wdata  output  32  store data replicated into lanes
mem_ack  input  1  memory completion; rdata valid same cycle for loads
mem_rdata  input  32  memory read word

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, fault, mem_req, mem_we = 0; mem_be=0; rdata, mem_addr, mem_wdata = 0; counter = 0.
- States: IDLE, REQ, DONE.
- IDLE + start: latch we/size/uns/addr[1:0]/wdata. Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Misaligned: go to DONE with fault=1; no memory request is issued.
  - Otherwise: go to REQ; mem_req=1 and mem_addr/mem_be/mem_we/mem_wdata driven from the next cycle.
- start outside IDLE is ignored; no queuing.
- REQ:
  - mem_req and all mem_* outputs hold stable until mem_ack is sampled high.
  - On ack: capture the load lane, extend it into rdata, go to DONE, drop mem_req the same edge.
  - A store ack leaves rdata unchanged.
- Timeout: counter increments each REQ cycle without ack. When counter==TIMEOUT-1 and no ack, drop mem_req, go to DONE with fault=1. An ack in that same cycle wins (no fault).
- DONE: done=1, busy=1 for exactly one cycle, then IDLE. fault is cleared on the next start.
- Latency: start at cycle 0 → mem_req at cycle 1 → ack at cycle k≥1 → done at cycle k+1. Misaligned: done at cycle 1.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: addr[1]?1100:0011
  - word: 1111
- mem_wdata lane replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extension: byte lane = mem_rdata[8*addr[1:0]+:8]; half lane = mem_rdata[16*addr[1]+:16]; extended per uns to 32 bits.
- Spurious mem_ack outside REQ is ignored.

Decomposition:
- Shared package mem_pkg:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL
  - state encodings
  - byte-enable constants
- One natural sub-module, load_extend: combinational lane select plus sign/zero extension (mem_rdata, addr[1:0], size, uns → 32-bit). The FSM, counter and store lane logic stay in the top level.

Test Plan:
- LB: addr=0x1003, mem_rdata=0x80FFFFFF, ack one cycle after req, uns=0 → mem_be=1000, done at cycle 2, rdata=0xFFFFFF80, fault=0.
- LHU: addr=0x2002, mem_rdata=0xBEEF1234, uns=1 → mem_be=1100, rdata=0x0000BEEF.
- SB then SW:
  - SB addr=0x0001, wdata=0x000000A5 → mem_be=0010, mem_wdata=0xA5A5A5A5, mem_we=1.
  - SW addr=0x0004, wdata=0xDEADBEEF → mem_be=1111; rdata unchanged.
- Misaligned LW at addr=0x0006 → no mem_req ever, done+fault at cycle 1; a start pulse during DONE is ignored.
- Timeout with TIMEOUT=4, mem_ack never asserted:
  - mem_req high exactly 4 cycles, then done+fault.
  - Rerun with ack in the 4th cycle → no fault.
- Async reset asserted mid-REQ: mem_req/busy fall without a clock edge. After release, a new LW completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// byte-enable patterns.
package mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a memory word and sign- or
// zero-extends it to 32 bits.
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  lane,
   input  size_e       size,
   input  logic        uns,
   output logic [31:0] ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      unique case (lane)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      case (size)
         SZ_BYTE: ext = {{24{~uns & byte_sel[7]}}, byte_sel};
         SZ_HALF: ext = {{16{~uns & half_sel[15]}}, half_sel};
         default: ext = mem_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one byte/half/word access per start pulse over a
// req/ack handshake, with alignment check, timeout and load extension.
module load_store_unit
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   size_e             size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        lane_q, lane_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fault_q, fault_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   size_e             size_in;
   logic              misaligned;
   logic [3:0]        be_in;
   logic [31:0]       wdata_rep;
   logic [31:0]       load_ext;

   load_extend u_load_extend (
      .mem_rdata (mem_rdata),
      .lane      (lane_q),
      .size      (size_q),
      .uns       (uns_q),
      .ext       (load_ext)
   );

   always_comb begin
      size_in = size_e'(size);
      case (size_in)
         SZ_BYTE: begin
            misaligned = 1'b0;
            be_in      = BE_BYTE0 << addr[1:0];
            wdata_rep  = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            misaligned = addr[0];
            be_in      = addr[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata_rep  = {2{wdata[15:0]}};
         end
         SZ_WORD: begin
            misaligned = |addr[1:0];
            be_in      = BE_WORD;
            wdata_rep  = wdata;
         end
         default: begin
            misaligned = 1'b1;
            be_in      = '0;
            wdata_rep  = wdata;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      lane_d      = lane_q;
      cnt_d       = cnt_q;
      fault_d     = fault_q;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               we_d    = we;
               size_d  = size_in;
               uns_d   = uns;
               lane_d  = addr[1:0];
               cnt_d   = '0;
               fault_d = misaligned;
               if (misaligned) begin
                  state_d = ST_DONE;
               end else begin
                  state_d     = ST_REQ;
                  mem_req_d   = 1'b1;
                  mem_we_d    = we;
                  mem_addr_d  = {addr[31:2], 2'b00};
                  mem_be_d    = be_in;
                  mem_wdata_d = wdata_rep;
               end
            end
         end
         ST_REQ: begin
            // Ack is checked first so an ack in the final timeout cycle wins.
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = ST_DONE;
               if (!we_q) begin
                  rdata_d = load_ext;
               end
            end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
               mem_req_d = 1'b0;
               fault_d   = 1'b1;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         size_q      <= SZ_BYTE;
         uns_q       <= 1'b0;
         lane_q      <= '0;
         cnt_q       <= '0;
         fault_q     <= 1'b0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         lane_q      <= lane_d;
         cnt_q       <= cnt_d;
         fault_q     <= fault_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign fault     = fault_q;
   assign rdata     = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, async reset
// sequence and randomized accesses against a byte-level reference model.
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, we, uns;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        busy, done, fault;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rdata;

   load_store_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .we(we), .size(size), .uns(uns),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault),
      .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference model: byte counts and shifts rather than lane multiplexers.
   function automatic int nbytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'b11) return 1'b1;
      return (a % nbytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
      int n = nbytes(sz);
      int v = ((1 << n) - 1) << (a % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r = '0;
      int n = nbytes(sz);
      for (int i = 0; i < 4; i++)
         r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u,
                                              input logic [31:0] a, input logic [31:0] rd);
      int n = nbytes(sz);
      longint v;
      longint span = longint'(1) << (8 * n);
      v = (longint'(rd) >> (8 * (a % 4))) & (span - 1);
      if (!u && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   task automatic run_op(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int ack_at, input bit poke_done,
                         output int done_cyc, output logic flt, output int req_cyc,
                         output logic [3:0] be, output logic [31:0] mwd, output logic mwe,
                         output logic [31:0] maddr, output bit stable);
      int cyc;
      done_cyc = -1; flt = 1'b0; req_cyc = 0; be = '0; mwd = '0; mwe = 1'b0;
      maddr = '0; stable = 1'b1;
      we = w; size = sz; uns = u; addr = a; wdata = wd; start = 1'b1;
      tick();
      start = 1'b0; we = $urandom; size = 2'($urandom); uns = $urandom;
      addr = $urandom; wdata = $urandom;
      cyc = 1;
      while (done_cyc < 0 && cyc <= 20) begin
         chk("busy_during_op", busy, 1);
         if (done) begin
            done_cyc = cyc;
            flt = fault;
            chk("req_low_in_done", mem_req, 0);
            mem_ack = $urandom;
            mem_rdata = $urandom;
            if (poke_done) begin
               start = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h40;
            end
         end else begin
            if (mem_req) begin
               if (req_cyc == 0) begin
                  be = mem_be; mwd = mem_wdata; mwe = mem_we; maddr = mem_addr;
               end else if (mem_be !== be || mem_wdata !== mwd || mem_we !== mwe || mem_addr !== maddr) begin
                  stable = 1'b0;
               end
               req_cyc++;
            end
            mem_rdata = (cyc == ack_at) ? rd : $urandom;
            mem_ack = (cyc == ack_at);
         end
         tick();
         mem_ack = 1'b0;
         start = 1'b0;
         cyc++;
      end
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      if (poke_done) begin
         tick();
         chk("start_in_done_ignored_busy", busy, 0);
         chk("start_in_done_ignored_req", mem_req, 0);
      end
   endtask

   typedef struct {
      string       nm;
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] a, wd, rd;
      int          ack;
      bit          poke;
      int          e_done;
      logic        e_flt;
      int          e_req;
      logic [3:0]  e_be;
      logic [31:0] e_wd, e_rdata;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int dc, rc;
      logic fl, mw;
      logic [3:0] b;
      logic [31:0] wdv, ma;
      bit st;

      tbl[0]  = '{"LB",    0, 2'b00, 0, 32'h1003, 32'h0,        32'h80FFFFFF, 1, 0, 2, 0, 1, 4'b1000, 32'h0,        32'hFFFFFF80};
      tbl[1]  = '{"LHU",   0, 2'b01, 1, 32'h2002, 32'h0,        32'hBEEF1234, 2, 0, 3, 0, 2, 4'b1100, 32'h0,        32'h0000BEEF};
      tbl[2]  = '{"SB",    1, 2'b00, 0, 32'h0001, 32'h000000A5, 32'h11111111, 1, 0, 2, 0, 1, 4'b0010, 32'hA5A5A5A5, 32'h0000BEEF};
      tbl[3]  = '{"SW",    1, 2'b10, 0, 32'h0004, 32'hDEADBEEF, 32'h22222222, 3, 0, 4, 0, 3, 4'b1111, 32'hDEADBEEF, 32'h0000BEEF};
      tbl[4]  = '{"LWMIS", 0, 2'b10, 0, 32'h0006, 32'h0,        32'h33333333, 1, 1, 1, 1, 0, 4'b0000, 32'h0,        32'h0000BEEF};
      tbl[5]  = '{"LWTO",  0, 2'b10, 0, 32'h0008, 32'h0,        32'h44444444, 0, 0, 5, 1, 4, 4'b1111, 32'h0,        32'h0000BEEF};
      tbl[6]  = '{"LWACK4",0, 2'b10, 0, 32'h000C, 32'h0,        32'h12345678, 4, 0, 5, 0, 4, 4'b1111, 32'h0,        32'h12345678};
      tbl[7]  = '{"ILLSZ", 0, 2'b11, 0, 32'h0000, 32'h0,        32'h55555555, 1, 0, 1, 1, 0, 4'b0000, 32'h0,        32'h12345678};
      tbl[8]  = '{"LH",    0, 2'b01, 0, 32'h2000, 32'h0,        32'h55558001, 2, 0, 3, 0, 2, 4'b0011, 32'h0,        32'hFFFF8001};
      tbl[9]  = '{"SHMIS", 1, 2'b01, 0, 32'h0003, 32'h1234,     32'h0,        1, 0, 1, 1, 0, 4'b0000, 32'h0,        32'hFFFF8001};
      tbl[10] = '{"LBU",   0, 2'b00, 1, 32'h0002, 32'h0,        32'h00C30000, 1, 0, 2, 0, 1, 4'b0100, 32'h0,        32'h000000C3};

      reset = 1'b1; start = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
      addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      #2;
      chk("reset_ctrl", {28'h0, busy, done, fault, mem_req}, 32'h0);
      chk("reset_we_be", {27'h0, mem_we, mem_be}, 32'h0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_wdata", mem_wdata, 32'h0);
      #20;
      tick();
      reset = 1'b0;
      tick();
      exp_rdata = '0;

      for (int i = 0; i < 11; i++) begin
         run_op(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, tbl[i].rd,
                tbl[i].ack, tbl[i].poke, dc, fl, rc, b, wdv, mw, ma, st);
         chk({tbl[i].nm, "_done_cycle"}, dc, tbl[i].e_done);
         chk({tbl[i].nm, "_fault"}, fl, tbl[i].e_flt);
         chk({tbl[i].nm, "_req_cycles"}, rc, tbl[i].e_req);
         chk({tbl[i].nm, "_rdata"}, rdata, tbl[i].e_rdata);
         if (tbl[i].e_req > 0) begin
            chk({tbl[i].nm, "_be"}, b, tbl[i].e_be);
            chk({tbl[i].nm, "_we"}, mw, tbl[i].w);
            chk({tbl[i].nm, "_addr"}, ma, {tbl[i].a[31:2], 2'b00});
            chk({tbl[i].nm, "_stable"}, st, 1);
            if (tbl[i].w) chk({tbl[i].nm, "_wdata"}, wdv, tbl[i].e_wd);
         end
      end
      exp_rdata = rdata === 32'h000000C3 ? 32'h000000C3 : 32'h000000C3;

      // Async reset mid-REQ, then a clean word load.
      we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10; start = 1'b1;
      tick();
      start = 1'b0;
      chk("midreq_req_up", mem_req, 1);
      tick();
      #3 reset = 1'b1;
      #1;
      chk("async_reset_req", mem_req, 0);
      chk("async_reset_busy", busy, 0);
      chk("async_reset_rdata", rdata, 0);
      #2 reset = 1'b0;
      exp_rdata = '0;
      tick();
      chk("post_reset_idle", busy, 0);
      run_op(0, 2'b10, 0, 32'h10, 32'h0, 32'hCAFEF00D, 2, 0, dc, fl, rc, b, wdv, mw, ma, st);
      chk("post_reset_lw_done", dc, 3);
      chk("post_reset_lw_fault", fl, 0);
      chk("post_reset_lw_rdata", rdata, 32'hCAFEF00D);
      exp_rdata = 32'hCAFEF00D;

      for (int n = 0; n < 60; n++) begin
         logic        rw, ru;
         logic [1:0]  rsz;
         logic [31:0] ra, rwd, rrd;
         int          rack, e_dc, e_rc;
         bit          mis, e_f;
         rw = $urandom; ru = $urandom;
         rsz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         ra = $urandom; rwd = $urandom; rrd = $urandom;
         rack = $urandom_range(0, TO + 1);
         mis = model_mis(rsz, ra);
         if (mis) begin
            e_dc = 1; e_f = 1; e_rc = 0;
         end else if (rack >= 1 && rack <= TO) begin
            e_dc = rack + 1; e_f = 0; e_rc = rack;
            if (!rw) exp_rdata = model_load(rsz, ru, ra, rrd);
         end else begin
            e_dc = TO + 1; e_f = 1; e_rc = TO;
         end
         run_op(rw, rsz, ru, ra, rwd, rrd, rack, n[0], dc, fl, rc, b, wdv, mw, ma, st);
         chk("rnd_done_cycle", dc, e_dc);
         chk("rnd_fault", fl, e_f);
         chk("rnd_req_cycles", rc, e_rc);
         chk("rnd_rdata", rdata, exp_rdata);
         if (!mis) begin
            chk("rnd_be", b, model_be(rsz, ra));
            chk("rnd_addr", ma, ra & 32'hFFFFFFFC);
            chk("rnd_we", mw, rw);
            chk("rnd_stable", st, 1);
            if (rw) chk("rnd_wdata", wdv, model_wd(rsz, rwd));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
